// File: rtl/bus_spi_pkg.sv
// rtl/bus_spi_pkg.sv - bus field layout, register offsets and state encoding shared by bus_spi
package bus_spi_pkg;
    localparam int BUS_WR_DATA_START = 0;
    localparam int BUS_WR_DATA_END   = 31;
    localparam int BUS_ADDR_START    = 32;
    localparam int BUS_ADDR_END      = 63;
    localparam int BUS_FIELD_RE      = 64;
    localparam int BUS_WE_START      = 65;
    localparam int BUS_WE_END        = 68;
    localparam int BUS_FIELD_RESET   = 69;
    localparam int BUS_FIELD_CLK     = 70;
    localparam int BUS_IN_WIDTH      = 71;

    localparam int BUS_RD_DATA_START = 0;
    localparam int BUS_RD_DATA_END   = 31;
    localparam int BUS_FIELD_WR_ACK  = 32;
    localparam int BUS_FIELD_RD_ACK  = 33;
    localparam int BUS_OUT_WIDTH     = 34;

    localparam logic [31:0] BUS_SPI_ADDR     = 32'h0200_0008;
    localparam logic [31:0] BUS_SPI_DATA_OFF = 32'd0;
    localparam logic [31:0] BUS_SPI_CTRL_OFF = 32'd4;

    typedef enum logic [1:0] {
        BUS_SPI_IDLE  = 2'd0,
        BUS_SPI_SHIFT = 2'd1,
        BUS_SPI_DONE  = 2'd2
    } bus_spi_state_t;

    function automatic logic [31:0] bus_spi_status(input logic busy, input logic rx_full,
                                                   input logic cs);
        return {23'b0, cs, 6'b0, rx_full, busy};
    endfunction
endpackage

// File: rtl/bus_spi_if.sv
// rtl/bus_spi_if.sv - SoC bus request/response bundle between the bus fabric and bus_spi
interface bus_spi_if;
    import bus_spi_pkg::*;

    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;

    modport master (output bus_in, input bus_out);
    modport slave  (input bus_in, output bus_out);
endinterface

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI transfer FSM, half-period divider and shifters; BUS_SPI_MODES_EN enables CPOL/CPHA
module spi_shift_engine
    import bus_spi_pkg::*;
(
    input  logic           clk,
    input  logic           reset_l,
    input  logic           start,
    input  logic [7:0]     tx_data,
    input  logic [7:0]     div,
    input  logic           cpol,
    input  logic           cpha,
    input  logic           miso,
    output bus_spi_state_t state,
    output logic           sck,
    output logic           mosi,
    output logic [7:0]     rx_data
);
    bus_spi_state_t state_next;
    logic [7:0] div_q, cnt, tx_sh, rx_sh;
    logic [3:0] edge_cnt;
    logic       sck_q, mosi_q, cpha_q;
    logic       cpol_live, cpha_live, tick, last_edge, sample_edge, shift_edge;

`ifdef BUS_SPI_MODES_EN
    assign cpol_live = cpol;
    assign cpha_live = cpha;
`else
    logic unused_mode;
    assign unused_mode = cpol ^ cpha;
    assign cpol_live   = 1'b0;
    assign cpha_live   = 1'b0;
`endif

    assign tick      = (state == BUS_SPI_SHIFT) && (cnt == 8'd0);
    assign last_edge = tick && (edge_cnt == 4'd15);
    // Current edge number is edge_cnt+1: CPHA=0 samples odd edges, CPHA=1 even ones.
    assign sample_edge = tick && (edge_cnt[0] == cpha_q);
    assign shift_edge  = tick && (edge_cnt[0] != cpha_q) && !last_edge;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= BUS_SPI_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUS_SPI_IDLE:  if (start) state_next = BUS_SPI_SHIFT;
            BUS_SPI_SHIFT: if (last_edge) state_next = BUS_SPI_DONE;
            BUS_SPI_DONE:  state_next = BUS_SPI_IDLE;
            default:       state_next = BUS_SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            div_q    <= 8'd0;
            cnt      <= 8'd0;
            edge_cnt <= 4'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else if (state == BUS_SPI_IDLE && start) begin
            div_q    <= div;
            cnt      <= div;
            edge_cnt <= 4'd0;
            sck_q    <= cpol_live;
            cpha_q   <= cpha_live;
            mosi_q   <= tx_data[7];
            // With CPHA=1 bit7 is re-driven on edge 1, so the shifter keeps it.
            tx_sh    <= cpha_live ? tx_data : {tx_data[6:0], 1'b0};
        end else if (state == BUS_SPI_SHIFT) begin
            if (tick) begin
                cnt      <= div_q;
                sck_q    <= ~sck_q;
                edge_cnt <= edge_cnt + 4'd1;
            end else begin
                cnt <= cnt - 8'd1;
            end
            if (sample_edge) rx_sh <= {rx_sh[6:0], miso};
            if (shift_edge) begin
                mosi_q <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end
        end
    end

    assign sck     = (state == BUS_SPI_IDLE) ? cpol_live : sck_q;
    assign mosi    = mosi_q;
    assign rx_data = rx_sh;
endmodule

// File: rtl/bus_spi.sv
// rtl/bus_spi.sv - SPI master bus slave: address decode, acks, DATA/CTRL/STATUS registers
module bus_spi
    import bus_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_l,
    bus_spi_if.slave    bus,
    input  logic [31:0] cfg,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_l
);
    logic [31:0] addr, wr_data, rd_data;
    logic [3:0]  we;
    logic        re, hit_data, hit_ctrl, data_wr, ctrl_wr, data_rd, stat_rd;
    logic        eng_idle, eng_done, start, busy;
    logic [7:0]  start_data, eng_rx, rx_byte, pend_data;
    logic        pend_valid, rx_full, cs, wr_ack, rd_ack;
    bus_spi_state_t eng_state;
    logic        unused_bits;

    assign addr    = bus.bus_in[BUS_ADDR_END:BUS_ADDR_START];
    assign wr_data = bus.bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];
    assign we      = bus.bus_in[BUS_WE_END:BUS_WE_START];
    assign re      = bus.bus_in[BUS_FIELD_RE];
    assign unused_bits = ^{bus.bus_in[BUS_FIELD_CLK], bus.bus_in[BUS_FIELD_RESET],
                           wr_data[31:8], cfg[31:10]};

    assign hit_data = (addr == BUS_SPI_ADDR + BUS_SPI_DATA_OFF);
    assign hit_ctrl = (addr == BUS_SPI_ADDR + BUS_SPI_CTRL_OFF);
    assign data_wr  = hit_data && (|we);
    assign ctrl_wr  = hit_ctrl && (|we);
    assign data_rd  = hit_data && re;
    assign stat_rd  = hit_ctrl && re;

    assign eng_idle   = (eng_state == BUS_SPI_IDLE);
    assign eng_done   = (eng_state == BUS_SPI_DONE);
    assign busy       = !eng_idle;
    // A held write takes priority; a fresh write colliding with it is dropped.
    assign start      = eng_idle && (pend_valid || data_wr);
    assign start_data = pend_valid ? pend_data : wr_data[7:0];

    spi_shift_engine u_engine (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (start),
        .tx_data (start_data),
        .div     (cfg[7:0]),
        .cpol    (cfg[8]),
        .cpha    (cfg[9]),
        .miso    (spi_miso),
        .state   (eng_state),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .rx_data (eng_rx)
    );

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wr_ack     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_data    <= 32'd0;
            pend_valid <= 1'b0;
            pend_data  <= 8'd0;
            rx_byte    <= 8'd0;
            rx_full    <= 1'b0;
            cs         <= 1'b0;
        end else begin
            // Held writes are acked in the cycle after DONE, while the engine sits in IDLE.
            wr_ack <= (data_wr && eng_idle && !pend_valid) || ctrl_wr ||
                      (eng_done && (pend_valid || data_wr));
            if (data_wr && !eng_idle && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_data  <= wr_data[7:0];
            end else if (start && pend_valid) begin
                pend_valid <= 1'b0;
            end
            if (ctrl_wr) cs <= wr_data[0];
            rd_ack  <= data_rd || stat_rd;
            rd_data <= data_rd ? {24'b0, rx_byte} :
                       stat_rd ? bus_spi_status(busy, rx_full, cs) : 32'd0;
            if (eng_done) begin
                rx_byte <= eng_rx;
                rx_full <= 1'b1;
            end else if (data_rd) begin
                rx_full <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.bus_out = '0;
        bus.bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = rd_data;
        bus.bus_out[BUS_FIELD_WR_ACK] = wr_ack;
        bus.bus_out[BUS_FIELD_RD_ACK] = rd_ack;
    end

    assign spi_cs_l = !cs;
endmodule

// File: tb/tb_bus_spi.sv
// tb/tb_bus_spi.sv - directed bench for bus_spi; mode-3 sequence depends on BUS_SPI_MODES_EN
module tb_bus_spi;
    import bus_spi_pkg::*;

    localparam logic [31:0] A_DATA = 32'h0200_0008;
    localparam logic [31:0] A_STAT = 32'h0200_000C;

    logic        clk = 1'b0;
    logic        reset_l;
    logic [31:0] cfg;
    logic [3:0]  we;
    logic        re;
    logic [31:0] addr, wdata;
    logic        loop_en, miso_tie;
    logic        spi_sck, spi_mosi, spi_miso, spi_cs_l;
    logic [7:0]  mosi_cap = 8'd0;
    int          rise_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    bus_spi_if bif();

    assign bif.bus_in = {clk, reset_l, we, re, addr, wdata};
    assign spi_miso   = loop_en ? spi_mosi : miso_tie;

    bus_spi dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .bus      (bif),
        .cfg      (cfg),
        .spi_miso (spi_miso),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_cs_l (spi_cs_l)
    );

    always #5 clk = ~clk;

    always @(posedge spi_sck) begin
        mosi_cap <= {mosi_cap[6:0], spi_mosi};
        rise_cnt <= rise_cnt + 1;
    end

    typedef struct {
        logic [3:0]  we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [33:0] exp_out;
        logic        exp_cs_l;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns bus_out one cycle after the request pulse.
    task automatic bus_op(input logic [3:0] w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output logic [33:0] resp);
        we = w; re = r; addr = a; wdata = d;
        @(negedge clk);
        we = 4'h0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
        resp = bif.bus_out;
    endtask

    task automatic wait_idle(input string name, output logic [33:0] resp);
        int n;
        n = 0;
        do begin
            bus_op(4'h0, 1'b1, A_STAT, 32'h0, resp);
            n++;
        end while (resp[0] && n < 200);
        check(name, {63'b0, resp[0]}, 64'd0);
    endtask

    task automatic watch(output int toggles, output int last_k, output int first_rise,
                         output int second_rise, output int bad_mosi);
        logic prev_sck, prev_mosi;
        int k;
        prev_sck = spi_sck; prev_mosi = spi_mosi;
        toggles = 0; last_k = -1; first_rise = -1; second_rise = -1; bad_mosi = 0; k = 0;
        while (toggles < 16 && k < 300) begin
            @(negedge clk);
            k++;
            if (spi_mosi !== prev_mosi && !(prev_sck === 1'b1 && spi_sck === 1'b0)) bad_mosi++;
            if (spi_sck !== prev_sck) begin
                toggles++;
                last_k = k;
                if (spi_sck === 1'b1) begin
                    if (first_rise < 0) first_rise = k;
                    else if (second_rise < 0) second_rise = k;
                end
            end
            prev_sck = spi_sck; prev_mosi = spi_mosi;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        logic [33:0] resp;
        int toggles, last_k, first_rise, second_rise, bad_mosi, r0, k, ack_k, n_ack;

        vecs[0]  = '{4'h0, 1'b1, A_STAT,        32'h0,         {2'b10, 32'h0},   1'b1};
        vecs[1]  = '{4'h1, 1'b0, A_STAT,        32'h1,         {2'b01, 32'h0},   1'b0};
        vecs[2]  = '{4'h0, 1'b1, A_STAT,        32'h0,         {2'b10, 32'h100}, 1'b0};
        vecs[3]  = '{4'h0, 1'b1, A_DATA,        32'h0,         {2'b10, 32'h0},   1'b0};
        vecs[4]  = '{4'h8, 1'b0, A_STAT,        32'hFFFF_FFFE, {2'b01, 32'h0},   1'b1};
        vecs[5]  = '{4'h0, 1'b1, A_STAT,        32'h0,         {2'b10, 32'h0},   1'b1};
        vecs[6]  = '{4'hF, 1'b0, 32'h0200_0010, 32'h1,         34'h0,            1'b1};
        vecs[7]  = '{4'h0, 1'b1, 32'h0200_0010, 32'h0,         34'h0,            1'b1};
        vecs[8]  = '{4'h0, 1'b1, 32'h0200_0000, 32'h0,         34'h0,            1'b1};
        vecs[9]  = '{4'h1, 1'b0, 32'h0200_000D, 32'h1,         34'h0,            1'b1};
        vecs[10] = '{4'h0, 1'b1, 32'h1200_000C, 32'h0,         34'h0,            1'b1};

        reset_l = 1'b0; cfg = 32'h0; we = 4'h0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
        loop_en = 1'b0; miso_tie = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus_out", bif.bus_out, 64'd0);
        check("rst_sck", spi_sck, 64'd0);
        check("rst_mosi", spi_mosi, 64'd0);
        check("rst_cs_l", spi_cs_l, 64'd1);
        reset_l = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            bus_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, resp);
            check($sformatf("vec%0d_bus", i), resp, vecs[i].exp_out);
            check($sformatf("vec%0d_cs_l", i), spi_cs_l, vecs[i].exp_cs_l);
        end

        // DIV=1 mode 0 loopback
        cfg = 32'h1; loop_en = 1'b1; r0 = rise_cnt;
        bus_op(4'hF, 1'b0, A_DATA, 32'hA5, resp);
        check("t1_wr_ack", resp, {2'b01, 32'h0});
        watch(toggles, last_k, first_rise, second_rise, bad_mosi);
        check("t1_toggles", toggles, 16);
        check("t1_shift_cycles", last_k, 32);
        check("t1_first_rise", first_rise, 2);
        check("t1_sck_period", second_rise - first_rise, 4);
        check("t1_mosi_on_fall", bad_mosi, 0);
        @(negedge clk);
        check("t1_rises", rise_cnt - r0, 8);
        check("t1_mosi_bits", mosi_cap, 8'hA5);
        bus_op(4'h0, 1'b1, A_STAT, 32'h0, resp);
        check("t1_status_full", resp, {2'b10, 32'h2});
        bus_op(4'h0, 1'b1, A_DATA, 32'h0, resp);
        check("t1_rx", resp, {2'b10, 32'hA5});
        bus_op(4'h0, 1'b1, A_STAT, 32'h0, resp);
        check("t1_status_clr", resp, {2'b10, 32'h0});

        // DIV=0, MISO tied high
        cfg = 32'h0; loop_en = 1'b0; miso_tie = 1'b1; r0 = rise_cnt;
        bus_op(4'h3, 1'b0, A_DATA, 32'h3C, resp);
        check("t2_wr_ack", resp, {2'b01, 32'h0});
        bus_op(4'h0, 1'b1, A_STAT, 32'h0, resp);
        check("t2_status_busy", resp, {2'b10, 32'h1});
        wait_idle("t2_done", resp);
        check("t2_status_after", resp, {2'b10, 32'h2});
        check("t2_rises", rise_cnt - r0, 8);
        check("t2_mosi_bits", mosi_cap, 8'h3C);
        bus_op(4'h0, 1'b1, A_DATA, 32'h0, resp);
        check("t2_rx", resp, {2'b10, 32'hFF});

        // Write while busy is held until the cycle after DONE
        cfg = 32'h0; loop_en = 1'b1;
        bus_op(4'hF, 1'b0, A_DATA, 32'h12, resp);
        check("t3_first_ack", resp, {2'b01, 32'h0});
        bus_op(4'hF, 1'b0, A_DATA, 32'h5A, resp);
        check("t3_held_no_ack", resp[BUS_FIELD_WR_ACK], 64'd0);
        k = 1; ack_k = -1;
        while (ack_k < 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (bif.bus_out[BUS_FIELD_WR_ACK]) ack_k = k;
        end
        check("t3_ack_cycle", ack_k, 17);
        check("t3_sck_idle", spi_sck, 64'd0);
        @(negedge clk);
        check("t3_ack_pulse", bif.bus_out[BUS_FIELD_WR_ACK], 64'd0);
        check("t3_sck_shift0", spi_sck, 64'd0);
        @(negedge clk);
        check("t3_sck_restart", spi_sck, 64'd1);
        wait_idle("t3_done", resp);
        bus_op(4'h0, 1'b1, A_DATA, 32'h0, resp);
        check("t3_rx", resp, {2'b10, 32'h5A});

        // CPOL=1 CPHA=1 requested
        cfg = 32'h301; loop_en = 1'b1;
        @(negedge clk);
`ifdef BUS_SPI_MODES_EN
        check("t5_sck_idle", spi_sck, 64'd1);
`else
        check("t5_sck_idle", spi_sck, 64'd0);
`endif
        r0 = rise_cnt;
        bus_op(4'hF, 1'b0, A_DATA, 32'h81, resp);
        check("t5_wr_ack", resp, {2'b01, 32'h0});
        watch(toggles, last_k, first_rise, second_rise, bad_mosi);
        check("t5_toggles", toggles, 16);
        check("t5_mosi_on_fall", bad_mosi, 0);
`ifdef BUS_SPI_MODES_EN
        check("t5_first_rise", first_rise, 4);
`else
        check("t5_first_rise", first_rise, 2);
`endif
        wait_idle("t5_done", resp);
        check("t5_rises", rise_cnt - r0, 8);
        check("t5_mosi_bits", mosi_cap, 8'h81);
        bus_op(4'h0, 1'b1, A_DATA, 32'h0, resp);
        check("t5_rx", resp, {2'b10, 32'h81});

        // Reset mid-transfer with cs asserted and a held write pending
        cfg = 32'h1; loop_en = 1'b1;
        bus_op(4'h1, 1'b0, A_STAT, 32'h1, resp);
        bus_op(4'hF, 1'b0, A_DATA, 32'hF0, resp);
        bus_op(4'hF, 1'b0, A_DATA, 32'h0F, resp);
        repeat (3) @(negedge clk);
        check("t6_cs_before", spi_cs_l, 64'd0);
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        check("t6_sck", spi_sck, 64'd0);
        check("t6_cs_l", spi_cs_l, 64'd1);
        check("t6_bus_out", bif.bus_out, 64'd0);
        n_ack = 0;
        repeat (60) begin
            @(negedge clk);
            if (bif.bus_out[BUS_FIELD_WR_ACK]) n_ack++;
        end
        check("t6_no_ack", n_ack, 0);
        bus_op(4'h0, 1'b1, A_STAT, 32'h0, resp);
        check("t6_status", resp, {2'b10, 32'h0});
        bus_op(4'hF, 1'b0, 32'h0200_0010, 32'h1, resp);
        check("t6_far_wr", resp, 64'd0);
        bus_op(4'h0, 1'b1, 32'h0200_0010, 32'h0, resp);
        check("t6_far_rd", resp, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
